// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Function : Shares one single-ported, variable-latency memory between the
//            instruction-fetch port and the data port. Data requests win
//            arbitration. A saturating streak counter forces a fetch grant
//            after MAX_D_STREAK back-to-back data grants so fetch always
//            makes progress. Each port gets a one-cycle ack pulse and a
//            stall signal for the hazard logic.
// Options  : MEM_ARB_TIMEOUT_EN - when defined, a grant that sees no mem_ack
//            for TIMEOUT cycles is abandoned. The port is acked with zero
//            data and the sticky err flag is raised.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              clr,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    // shared memory
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    // status
    output logic              busy,
    output logic              err
);

    // The streak counter is 4 bits wide, so MAX_D_STREAK can be at most 15.
    localparam logic [3:0] c_STREAK_MAX = 4'(MAX_D_STREAK);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GNT_I  = 3'd1,
        S_GNT_D  = 3'd2,
        S_DONE_I = 3'd3,
        S_DONE_D = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_streak;   // data grants taken while a fetch was waiting
    logic       r_kill;     // fetch in flight was killed; suppress its ack

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_err;
    logic               w_tmo_hit;

    // The last allowed grant cycle without an ack ends the grant.
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);
    assign err       = r_err;
`else
    assign err = 1'b0;
`endif

    logic w_if_pending;
    logic w_streak_sat;
    logic w_pick_d;
    logic w_pick_i;

    // Arbitration: a live fetch beats data only once the streak has saturated.
    assign w_if_pending = if_req & ~if_kill;
    assign w_streak_sat = (r_streak == c_STREAK_MAX);
    assign w_pick_d     = d_req & ~(w_if_pending & w_streak_sat);
    assign w_pick_i     = ~w_pick_d & w_if_pending;

    assign busy     = (r_state != S_IDLE);
    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

    // Main FSM. All handshake outputs are registered here. The async clear
    // drops mem_req at once, which aborts any transaction in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_streak  <= 4'd0;
            r_kill    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_ack    <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_kill <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    if (w_pick_d) begin
                        r_state   <= S_GNT_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (w_if_pending) begin
                            if (!w_streak_sat) begin
                                r_streak <= r_streak + 4'd1;
                            end
                        end else if (!if_req) begin
                            r_streak <= 4'd0;
                        end
                    end else if (w_pick_i) begin
                        r_state   <= S_GNT_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        r_streak  <= 4'd0;
                    end else if (!if_req) begin
                        r_streak <= 4'd0;
                    end
                end

                S_GNT_I: begin
                    // A kill arriving in any grant cycle, including the ack
                    // cycle, discards the result.
                    if (if_kill) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        r_state <= S_DONE_I;
                        if (!(r_kill || if_kill)) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        mem_req <= 1'b0;
                        r_state <= S_DONE_I;
                        r_err   <= 1'b1;
                        if (!(r_kill || if_kill)) begin
                            if_ack   <= 1'b1;
                            if_rdata <= '0;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end

                S_GNT_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        r_state <= S_DONE_D;
                        d_ack   <= 1'b1;
                        // Stores leave the load-data register untouched.
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        mem_req <= 1'b0;
                        r_state <= S_DONE_D;
                        r_err   <= 1'b1;
                        d_ack   <= 1'b1;
                        d_rdata <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end

                S_DONE_I: begin
                    if_ack  <= 1'b0;
                    r_kill  <= 1'b0;
                    r_state <= S_IDLE;
                end

                S_DONE_D: begin
                    d_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Function : Directed, self-checking bench for mem_port_arbiter. The bench
//            plays the role of the memory by driving mem_ack and mem_rdata
//            by hand. Expected values are worked out by hand for each step.
// Options  : MEM_ARB_TIMEOUT_EN enables the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        clr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_D_STREAK (4),
        .TIMEOUT      (8)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_if_ack",  32'(if_ack),  32'd0);
        chk("rst_d_ack",   32'(d_ack),   32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_if_rdata", if_rdata,    32'd0);
        tick();
        clr = 1'b0;
        tick();

        // ---------------- single fetch, ack two cycles after mem_req
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("t1_stall_req", 32'(if_stall), 32'd1);
        chk("t1_idle_busy", 32'(busy),     32'd0);
        tick();
        chk("t1_mem_req",  32'(mem_req), 32'd1);
        chk("t1_mem_addr", mem_addr,     32'h10);
        chk("t1_mem_we",   32'(mem_we),  32'd0);
        chk("t1_busy",     32'(busy),    32'd1);
        tick();
        chk("t1_hold_req",  32'(mem_req),  32'd1);
        chk("t1_hold_stall", 32'(if_stall), 32'd1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_if_ack",   32'(if_ack),   32'd1);
        chk("t1_if_rdata", if_rdata,      32'hDEADBEEF);
        chk("t1_req_drop", 32'(mem_req),  32'd0);
        chk("t1_stall_off", 32'(if_stall), 32'd0);
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        chk("t1_ack_pulse", 32'(if_ack), 32'd0);
        chk("t1_idle",      32'(busy),   32'd0);
        if_req = 1'b0;
        tick();

        // ---------------- collision: store wins, then the fetch
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55;
        tick();
        chk("t2_mem_we",    32'(mem_we),  32'd1);
        chk("t2_mem_addr",  mem_addr,     32'h40);
        chk("t2_mem_wdata", mem_wdata,    32'h55);
        chk("t2_if_stall",  32'(if_stall), 32'd1);
        chk("t2_d_stall",   32'(d_stall), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        chk("t2_d_ack",     32'(d_ack),  32'd1);
        chk("t2_no_if_ack", 32'(if_ack), 32'd0);
        chk("t2_st_rdata",  d_rdata,     32'd0);
        chk("t2_req_drop",  32'(mem_req), 32'd0);
        mem_ack = 1'b0;
        tick();
        chk("t2_d_ack_pulse", 32'(d_ack), 32'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("t2_i_req",  32'(mem_req), 32'd1);
        chk("t2_i_addr", mem_addr,     32'h20);
        chk("t2_i_we",   32'(mem_we),  32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        chk("t2_if_ack",   32'(if_ack), 32'd1);
        chk("t2_if_rdata", if_rdata,    32'h12345678);
        mem_ack = 1'b0;
        tick();
        if_req = 1'b0;
        tick();

        // ---------------- starvation bound: 4 data, 1 fetch, data again
        if_req = 1'b1; if_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk($sformatf("t3_req_%0d", g), 32'(mem_req), 32'd1);
            chk($sformatf("t3_addr_%0d", g), mem_addr, (g == 4) ? 32'h30 : 32'h80);
            mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(g);
            tick();
            if (g == 4) begin
                chk("t3_fetch_ack",   32'(if_ack), 32'd1);
                chk("t3_fetch_noack", 32'(d_ack),  32'd0);
                chk("t3_fetch_rdata", if_rdata,    32'hA4);
            end else begin
                chk($sformatf("t3_d_ack_%0d", g),  32'(d_ack),  32'd1);
                chk($sformatf("t3_no_if_%0d", g), 32'(if_ack), 32'd0);
                chk($sformatf("t3_rdata_%0d", g), d_rdata, 32'hA0 + 32'(g));
            end
            mem_ack = 1'b0;
            tick();
            chk($sformatf("t3_idle_%0d", g), 32'(busy), 32'd0);
            if (g == 4) if_req = 1'b0;
            if (g == 5) d_req = 1'b0;
        end

        // ---------------- kill in IDLE, then kill during GNT_I
        if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h50;
        tick();
        chk("t4_kill_idle_busy", 32'(busy),    32'd0);
        chk("t4_kill_idle_req",  32'(mem_req), 32'd0);
        if_kill = 1'b0;
        tick();
        chk("t4_gnt_addr", mem_addr, 32'h50);
        if_kill = 1'b1;
        tick();
        chk("t4_req_held", 32'(mem_req), 32'd1);
        if_kill = 1'b0; if_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
        tick();
        chk("t4_no_if_ack", 32'(if_ack), 32'd0);
        chk("t4_rdata_kept", if_rdata,   32'hA4);
        chk("t4_done_busy", 32'(busy),   32'd1);
        mem_ack = 1'b0;
        tick();
        chk("t4_idle_busy",  32'(busy),   32'd0);
        chk("t4_still_noack", 32'(if_ack), 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
        tick();
        chk("t4_d_addr", mem_addr, 32'h90);
        mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        chk("t4_d_ack",   32'(d_ack), 32'd1);
        chk("t4_d_rdata", d_rdata,    32'h77);
        mem_ack = 1'b0;
        tick();
        d_req = 1'b0;
        tick();

        // ---------------- asynchronous clear in GNT_D
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'h99;
        tick();
        chk("t5_pre_req", 32'(mem_req), 32'd1);
        #1 clr = 1'b1;
        #1;
        chk("t5_clr_req",    32'(mem_req), 32'd0);
        chk("t5_clr_busy",   32'(busy),    32'd0);
        chk("t5_clr_d_ack",  32'(d_ack),   32'd0);
        chk("t5_clr_if_ack", 32'(if_ack),  32'd0);
        chk("t5_clr_addr",   mem_addr,     32'd0);
        chk("t5_clr_rdata",  d_rdata,      32'd0);
        #1 clr = 1'b0;
        tick();
        chk("t5_new_req",   32'(mem_req), 32'd1);
        chk("t5_new_addr",  mem_addr,     32'h60);
        chk("t5_new_wdata", mem_wdata,    32'h99);
        chk("t5_new_we",    32'(mem_we),  32'd1);
        mem_ack = 1'b1;
        tick();
        chk("t5_new_ack", 32'(d_ack), 32'd1);
        mem_ack = 1'b0;
        tick();
        d_req = 1'b0; d_we = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // ---------------- timeout after 8 grant cycles
        if_req = 1'b1; if_addr = 32'h70;
        tick();
        chk("t6_req_0", 32'(mem_req), 32'd1);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("t6_req_%0d", k), 32'(mem_req), 32'd1);
        end
        tick();
        chk("t6_req_drop", 32'(mem_req), 32'd0);
        chk("t6_if_ack",   32'(if_ack),  32'd1);
        chk("t6_rdata",    if_rdata,     32'd0);
        chk("t6_err",      32'(err),     32'd1);
        tick();
        chk("t6_err_sticky", 32'(err), 32'd1);
        if_req = 1'b0;
        tick();
        chk("t6_err_sticky2", 32'(err), 32'd1);
        clr = 1'b1;
        #1;
        chk("t6_err_clr", 32'(err), 32'd0);
        clr = 1'b0;
        tick();
`else
        chk("t6_err_tied", 32'(err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
